// File: rtl/cache_refill_unit.sv
// Block refill engine: optional dirty write-back, beat-wise fill, one-cycle block commit.
// Define CACHE_REFILL_CRITICAL_WORD_EN to start the fill at the missed word and wrap.
module cache_refill_unit #(
  parameter int asize  = 32,
  parameter int dsize  = 32,
  parameter int bbits  = 5,
  parameter int bsize  = 8 << bbits,
  parameter int nbeats = bsize / dsize
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             wb,
  input  logic [asize-1:0] fill_addr,
  input  logic [asize-1:0] wb_addr,
  input  logic [bsize-1:0] wb_block,
  output logic             busy,
  output logic             done,
  output logic [asize-1:0] core_addr,
  output logic [bsize-1:0] block_in,
  output logic             bwrite,
  output logic [asize-1:0] mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [dsize-1:0] mem_wdata,
  input  logic [dsize-1:0] mem_rdata,
  input  logic             mem_ready
);

  localparam int cw = bbits - 2;
  localparam logic [asize-1:0] off_mask = {{(asize-bbits){1'b0}}, {bbits{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_FILL   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [cw-1:0]    beat_q, beat_d;
  logic [asize-1:0] fill_addr_q, fill_addr_d;
  logic [asize-1:0] wb_addr_q, wb_addr_d;
  logic [bsize-1:0] wb_block_q, wb_block_d;
  logic [bsize-1:0] buf_q, buf_d;

  logic [cw-1:0]    beat_nxt_s;
  logic [cw-1:0]    widx_s;
  logic [cw-1:0]    start_in_s;
  logic [cw-1:0]    start_q_s;
  logic [asize-1:0] addr_sel_s;

  // Fill start beat: the missed word when critical-word-first is enabled, else word 0
  always_comb begin
`ifdef CACHE_REFILL_CRITICAL_WORD_EN
    start_in_s = fill_addr[bbits-1:2];
    start_q_s  = fill_addr_q[bbits-1:2];
`else
    start_in_s = {cw{1'b0}};
    start_q_s  = {cw{1'b0}};
`endif
  end

  // Word 0 is the MSB word, so beat k lives at slice index nbeats-1-k == ~k
  assign widx_s     = ~beat_q;
  assign beat_nxt_s = beat_q + {{(cw-1){1'b0}}, 1'b1};

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      beat_q      <= {cw{1'b0}};
      fill_addr_q <= {asize{1'b0}};
      wb_addr_q   <= {asize{1'b0}};
      wb_block_q  <= {bsize{1'b0}};
      buf_q       <= {bsize{1'b0}};
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      fill_addr_q <= fill_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_block_q  <= wb_block_d;
      buf_q       <= buf_d;
    end
  end

  // Next-state, beat counter and buffer update
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    fill_addr_d = fill_addr_q;
    wb_addr_d   = wb_addr_q;
    wb_block_d  = wb_block_q;
    buf_d       = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fill_addr_d = fill_addr;
          wb_addr_d   = wb_addr;
          wb_block_d  = wb_block;
          if (wb) begin
            state_d = S_WB;
            beat_d  = {cw{1'b0}};
          end else begin
            state_d = S_FILL;
            beat_d  = start_in_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        if (mem_ready) begin
          if (beat_q == {cw{1'b1}}) begin
            state_d = S_FILL;
            beat_d  = start_q_s;
          end else begin
            beat_d  = beat_nxt_s;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          buf_d[widx_s*dsize +: dsize] = mem_rdata;
          beat_d = beat_nxt_s;
          if (beat_nxt_s == start_q_s) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only; everything is zero outside its phase
  always_comb begin
    addr_sel_s = (state_q == S_WB) ? wb_addr_q : fill_addr_q;
    busy       = 1'b0;
    done       = 1'b0;
    bwrite     = 1'b0;
    core_addr  = {asize{1'b0}};
    block_in   = {bsize{1'b0}};
    mem_addr   = {asize{1'b0}};
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = {dsize{1'b0}};
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_WB: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = (addr_sel_s & ~off_mask) | {{(asize-bbits){1'b0}}, beat_q, 2'b00};
        mem_wdata = wb_block_q[widx_s*dsize +: dsize];
      end
      S_FILL: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = (addr_sel_s & ~off_mask) | {{(asize-bbits){1'b0}}, beat_q, 2'b00};
      end
      S_COMMIT: begin
        busy      = 1'b1;
        done      = 1'b1;
        bwrite    = 1'b1;
        core_addr = fill_addr_q;
        block_in  = buf_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed bench for cache_refill_unit: fill, write-back+fill, stalls, busy-ignore, reset abort, critical word.
module tb_cache_refill_unit;
  logic         CLK, RESET, start, wb;
  logic [31:0]  fill_addr, wb_addr;
  logic [255:0] wb_block;
  logic         busy, done, bwrite, mem_rd, mem_wr, mem_ready;
  logic [31:0]  core_addr, mem_addr, mem_wdata, mem_rdata;
  logic [255:0] block_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulse_a  = -1;
  int pulse_b  = -1;
  logic [255:0] exp_fill, wb_blk;

  cache_refill_unit dut (
    .CLK(CLK), .RESET(RESET), .start(start), .wb(wb), .fill_addr(fill_addr),
    .wb_addr(wb_addr), .wb_block(wb_block), .busy(busy), .done(done),
    .core_addr(core_addr), .block_in(block_in), .bwrite(bwrite),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic w, input logic [31:0] wa, input logic [31:0] fa, input logic [255:0] blk);
    @(negedge CLK);
    start = 1'b1; wb = w; wb_addr = wa; fill_addr = fa; wb_block = blk;
    @(posedge CLK);
    cyc = 1;
  endtask

  task automatic do_beat(input logic is_wr, input logic [31:0] ea, input logic [31:0] ewd, input int stalls);
    for (int s = 0; s <= stalls; s++) begin
      @(negedge CLK);
      start = (cyc == pulse_a) || (cyc == pulse_b);
      check_val("busy", busy, 1);
      check_val(is_wr ? "mem_wr" : "mem_rd", is_wr ? mem_wr : mem_rd, 1);
      check_val("rd_wr_excl", mem_rd & mem_wr, 0);
      check_val("mem_addr", mem_addr, ea);
      if (is_wr) check_val("mem_wdata", mem_wdata, ewd);
      check_val("bwrite_early", bwrite, 0);
      mem_ready = (s == stalls);
      mem_rdata = (s == stalls) ? (32'h1000 + {29'd0, mem_addr[4:2]}) : 32'hDEAD_BEEF;
      @(posedge CLK);
      cyc++;
    end
  endtask

  task automatic commit(input logic [31:0] efa, input logic [255:0] eblk);
    @(negedge CLK);
    start = (cyc == pulse_a) || (cyc == pulse_b);
    mem_ready = 1'b0;
    check_val("bwrite", bwrite, 1);
    check_val("done", done, 1);
    check_val("busy_commit", busy, 1);
    check_val("rd_commit", mem_rd | mem_wr, 0);
    check_val("block_in", block_in, eblk);
    check_val("core_addr", core_addr, efa);
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    start = 1'b0;
    check_val("busy_after", busy, 0);
    check_val("done_after", done, 0);
    check_val("bwrite_after", bwrite, 0);
  endtask

  task automatic plain_fill(input logic [31:0] fa, input int stalls);
    launch(1'b0, 32'h0, fa, 256'h0);
    for (int k = 0; k < 8; k++) do_beat(1'b0, (fa & 32'hFFFF_FFE0) + 32'(4 * k), 32'h0, stalls);
    commit(fa, exp_fill);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; wb = 1'b0; fill_addr = 32'h0; wb_addr = 32'h0;
    wb_block = 256'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_fill[255 - 32*k -: 32] = 32'h1000 + 32'(k);
      wb_blk[255 - 32*k -: 32]   = 32'hA0 + 32'(k);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_bwrite", bwrite, 0);
    check_val("rst_mem_rd", mem_rd, 0);
    check_val("rst_mem_wr", mem_wr, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_core_addr", core_addr, 0);
    check_val("rst_block_in", block_in, 0);
    RESET = 1'b0;

    // clean fill, commit in cycle 9
    plain_fill(32'h0000_1040, 0);

    // write-back then fill, commit in cycle 17
    launch(1'b1, 32'h0000_2040, 32'h0000_1040, wb_blk);
    for (int k = 0; k < 8; k++) do_beat(1'b1, 32'h2040 + 32'(4 * k), 32'hA0 + 32'(k), 0);
    for (int k = 0; k < 8; k++) do_beat(1'b0, 32'h1040 + 32'(4 * k), 32'h0, 0);
    commit(32'h0000_1040, exp_fill);

    // two stall cycles per beat, commit in cycle 25
    plain_fill(32'h0000_1040, 2);

    // start pulses while busy are ignored
    pulse_a = 3; pulse_b = 9;
    plain_fill(32'h0000_1040, 0);
    pulse_a = -1; pulse_b = -1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_val("ignored_busy", busy, 0);
      check_val("ignored_rd", mem_rd, 0);
      check_val("ignored_done", done, 0);
    end

    // reset asserted in cycle 4 of a fill
    launch(1'b0, 32'h0, 32'h0000_1040, 256'h0);
    for (int k = 0; k < 3; k++) do_beat(1'b0, 32'h1040 + 32'(4 * k), 32'h0, 0);
    @(negedge CLK);
    start = 1'b0;
    check_val("abort_addr", mem_addr, 32'h104C);
    RESET = 1'b1; mem_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0; mem_ready = 1'b0;
    check_val("abort_rd", mem_rd, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_addr0", mem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_val("abort_bwrite", bwrite, 0);
      check_val("abort_done", done, 0);
    end
    plain_fill(32'h0000_1040, 0);

    // fill at word offset 0x14: wrapped order with critical word, else in order
    launch(1'b0, 32'h0, 32'h0000_1074, 256'h0);
    for (int i = 0; i < 8; i++) begin
`ifdef CACHE_REFILL_CRITICAL_WORD_EN
      do_beat(1'b0, 32'h1060 + 32'(4 * ((5 + i) % 8)), 32'h0, 0);
`else
      do_beat(1'b0, 32'h1060 + 32'(4 * i), 32'h0, 0);
`endif
    end
    commit(32'h0000_1074, exp_fill);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_refill_unit.md
# cache_refill_unit

Block transfer engine between `cache_core` and the word-wide memory port. On a miss it optionally writes back the evicted dirty block as `dsize`-bit beats, then reads the new block beat by beat, assembles it, and commits it to `cache_core` with a one-cycle `bwrite` pulse. It sits directly downstream of `cache_core`'s `block_out` and directly upstream of its `block_in`/`bwrite` inputs.

## Interface
- `asize`, default 32: address width.
- `dsize`, default 32: memory beat width; fixed at 32.
- `bbits`, default 5: block offset bits.
- `bsize`, default `8<<bbits` (256): block width.
- `nbeats`, default `bsize/dsize` (8): beats per block.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `wb`  in  1  with `start`: perform write-back before fill.
- `fill_addr`  in  asize  miss address; offset bits select critical word only.
- `wb_addr`  in  asize  evicted block address; offset bits ignored.
- `wb_block`  in  bsize  evicted block, from `cache_core.block_out`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; coincides with `bwrite`.
- `core_addr`  out  asize  address driven to `cache_core` during commit (= captured `fill_addr`).
- `block_in`  out  bsize  assembled block to `cache_core`.
- `bwrite`  out  1  one-cycle block-commit strobe to `cache_core`.
- `mem_addr`  out  asize  beat address, low 2 bits always 0.
- `mem_rd`  out  1  read beat request.
- `mem_wr`  out  1  write beat request.
- `mem_wdata`  out  dsize  write-back beat data.
- `mem_rdata`  in  dsize  read beat data, valid when `mem_ready` and `mem_rd`.
- `mem_ready`  in  1  beat accepted/completed this cycle.

## Operation
- States: IDLE, WB, FILL, COMMIT.
- IDLE: `start`=1 captures `fill_addr`, `wb_addr`, `wb_block` and `wb`. If `wb`=1, next state is WB; otherwise next state is FILL. The beat counter is loaded.
- Beat counter is (bbits-2) bits wide and wraps modulo `nbeats`. Beat k maps to block bits [bsize-1-k*dsize : bsize-(k+1)*dsize], so word 0 is the MSB word. This matches the `cache_core` packing.
- `mem_addr` = {block address[asize-1:bbits], beat, 2'b00}.
- WB: asserts `mem_wr` with `mem_wdata` = captured word[beat]. On `mem_ready`, the counter advances. After beat `nbeats`-1 is accepted, the block goes to FILL with the counter reset to the fill start beat.
- FILL: asserts `mem_rd`. On `mem_ready`, `mem_rdata` is written into buffer word[beat] and the counter advances. After the `nbeats`-th beat, the block goes to COMMIT.
- COMMIT: `bwrite`=1 and `done`=1 for exactly one cycle, with `block_in` = buffer and `core_addr` = `fill_addr`. Next state is IDLE.
- Request/address/data outputs are held stable until `mem_ready`. `mem_rd` and `mem_wr` are never high together. `mem_ready` is ignored when neither is asserted.
- `start` while busy is ignored and not queued.
- RESET: synchronous; state goes to IDLE, counter and buffer clear to 0, and every output is 0 on the next cycle. The memory request is dropped mid-burst, and no `bwrite` or `done` is issued for the aborted request.
- Reset values: `busy`, `done`, `bwrite`, `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_wdata`, `core_addr`, `block_in` = 0.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `mem_ready` or `start` to outputs.
- `start` is sampled at edge 0. The first request is visible in cycle 1, and `busy` is high from cycle 1 through the COMMIT cycle.
- One beat completes per cycle when `mem_ready` is held high.
- Fill only, `mem_ready` always 1: `mem_rd` in cycles 1–8, COMMIT in cycle 9, `busy` low in cycle 10. A new `start` is accepted in cycle 10.
- Write-back + fill: `mem_wr` in cycles 1–8, `mem_rd` in cycles 9–16, COMMIT in cycle 17.
- Each cycle with `mem_ready`=0 adds one cycle.

## Configuration
- `CACHE_REFILL_CRITICAL_WORD_EN` defined: the FILL phase starts at beat `fill_addr[bbits-1:2]` and wraps (e.g. offset 0x14 gives order 5,6,7,0,1,2,3,4). Each word is still placed at its own block position. WB always starts at beat 0.
- Not defined: FILL always runs beats 0..7; `fill_addr[bbits-1:0]` is ignored.

## Test plan
- Clean fill: `start`, `wb`=0, `fill_addr`=0x0000_1040, memory returns 0x1000+k for word k, `mem_ready`=1 -> `mem_addr` 0x1040..0x105C, `bwrite` and `done` in cycle 9, `block_in` = {0x1000,…,0x1007} MSB-first.
- Write-back then fill: `wb`=1, `wb_addr`=0x0000_2040, `wb_block` words 0xA0..0xA7 -> `mem_wr` beats at 0x2040..0x205C with data 0xA0..0xA7, then the fill at `fill_addr`, `bwrite` in cycle 17.
- Stalls: `mem_ready` low for 2 cycles on every beat -> address and data stable during stalls, fill-only commit in cycle 25, data correct.
- Busy/ignore: `start` pulsed in cycles 3 and 9 of a fill -> exactly one `done`, and no second request started.
- Reset mid-burst: `RESET` asserted in cycle 4 of a fill -> `mem_rd`=0 and `busy`=0 next cycle, no `bwrite` ever, and a new `start` afterwards completes normally.
- With `CACHE_REFILL_CRITICAL_WORD_EN`, `fill_addr`=0x0000_1074 -> read addresses 0x1074, 0x1078, 0x107C, 0x1060, …, 0x1070, and `block_in` identical to the in-order case.
